// File: rtl/axi_dma_r.sv
// ---------------------------------------------------------------------------
// axi_dma_r
//
// Purpose:
//   Single-channel read DMA. Software programs a source AXI byte address, a
//   destination local-RAM word address and a word count through a small
//   register file, then sets CR.EN. The block issues INCR bursts of 32-bit
//   beats on the AXI read channels and writes every returned beat straight
//   into the local RAM. Bursts are at most 16 beats and never cross a 4 KB
//   boundary. Completion is reported with CR.DONE and a one-cycle dma_done.
//
// Registers (byte address on apb_a):
//   0x0 CR         bit0 EN, bit1 DONE, bit2 ERR (other bits read 0)
//   0x4 SRC_SA     AXI byte address, bits[1:0] forced to 0
//   0x8 DST_SA     RAM word address (low RAM_AW bits kept)
//   0xC DMA_LENGTH word count
//   Writes are only accepted while the FSM is idle.
//
// Ports:
//   usr_clk, usr_reset                  clock, synchronous active-high reset
//   apb_a / apb_d / apb_we / apb_q      register access (read is combinational)
//   usr_ar*                             AXI read-address channel
//   usr_r*                              AXI read-data channel
//   ram_we / ram_a / ram_d              local RAM write port
//   dma_done                            one-cycle completion pulse
//
// Optional feature macro: AXI_DMA_R_RESP_CHECK_EN
//   When defined, a beat with usr_rresp != OKAY sets CR.ERR; the current
//   burst still completes and the transfer then ends without further AR.
//   When undefined, usr_rresp is ignored and CR.ERR reads 0.
// ---------------------------------------------------------------------------
module axi_dma_r #(
    parameter int AXI_AW = 32,
    parameter int AXI_LW = 8,
    parameter int RAM_AW = 20,
    parameter int APB_AW = 12
) (
    input  logic              usr_clk,
    input  logic              usr_reset,
    input  logic [APB_AW-1:0] apb_a,
    input  logic [31:0]       apb_d,
    input  logic              apb_we,
    output logic [31:0]       apb_q,
    output logic [AXI_AW-1:0] usr_araddr,
    output logic [AXI_LW-1:0] usr_arlen,
    output logic [2:0]        usr_arsize,
    output logic [1:0]        usr_arburst,
    output logic              usr_arvalid,
    input  logic              usr_arready,
    input  logic [31:0]       usr_rdata,
    input  logic [1:0]        usr_rresp,
    input  logic              usr_rlast,
    input  logic              usr_rvalid,
    output logic              usr_rready,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_a,
    output logic [31:0]       ram_d,
    output logic              dma_done
);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

    state_t r_state;
    state_t w_nextState;

    logic              r_en;
    logic              r_done;
    logic [AXI_AW-1:0] r_src;
    logic [RAM_AW-1:0] r_dst;
    logic [31:0]       r_len;
    logic [AXI_AW-1:0] r_araddr;
    logic [RAM_AW-1:0] r_ramAddr;
    logic [31:0]       r_remain;
    logic [4:0]        r_blen;

    logic              w_beat;
    logic [31:0]       w_remainNext;
    logic [10:0]       w_bndBeats;
    logic [4:0]        w_cap;
    logic [4:0]        w_blen;
    logic              w_err;
    logic              w_stop;

    assign usr_arsize  = 3'd2;
    assign usr_arburst = 2'b01;

    assign w_beat       = (r_state == S_R) && usr_rvalid;
    assign w_remainNext = r_remain - 32'd1;

    // Beats left before the next 4 KB boundary; araddr is word aligned, so
    // this is always at least 1.
    assign w_bndBeats = 11'((13'h1000 - {1'b0, r_araddr[11:0]}) >> 2);
    assign w_cap      = (r_remain < 32'd16) ? r_remain[4:0] : 5'd16;
    assign w_blen     = ({6'b0, w_cap} > w_bndBeats) ? w_bndBeats[4:0] : w_cap;

`ifdef AXI_DMA_R_RESP_CHECK_EN
    logic r_err;
    logic w_beatErr;

    assign w_beatErr = (usr_rresp != 2'b00);
    assign w_err     = r_err;
    // Stop after this burst if an error was seen earlier or on this beat.
    assign w_stop    = r_err | w_beatErr;

    // Register writes happen only in IDLE and beats only in R, so the clear
    // and set conditions never collide.
    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            r_err <= 1'b0;
        end else if ((r_state == S_IDLE) && apb_we && (apb_a == APB_AW'(0)) && apb_d[0]) begin
            r_err <= 1'b0;
        end else if (w_beat && w_beatErr) begin
            r_err <= 1'b1;
        end
    end
`else
    logic w_unusedResp;

    assign w_unusedResp = ^usr_rresp;
    assign w_err        = 1'b0;
    assign w_stop       = 1'b0;
`endif

    // State register.
    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_en && (r_len != 32'd0)) begin
                    w_nextState = S_AR;
                end
            end
            S_AR: begin
                if (usr_arready) begin
                    w_nextState = S_R;
                end
            end
            S_R: begin
                if (usr_rvalid && usr_rlast) begin
                    w_nextState = ((w_remainNext == 32'd0) || w_stop) ? S_DONE : S_AR;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Output logic. The zero-length case pulses dma_done from IDLE; EN is
    // cleared on that same edge, so the pulse lasts exactly one cycle.
    always_comb begin
        usr_arvalid = 1'b0;
        usr_araddr  = '0;
        usr_arlen   = '0;
        usr_rready  = 1'b0;
        ram_we      = 1'b0;
        ram_a       = '0;
        ram_d       = '0;
        dma_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                dma_done = r_en && (r_len == 32'd0);
            end
            S_AR: begin
                usr_arvalid = 1'b1;
                usr_araddr  = r_araddr;
                usr_arlen   = AXI_LW'(w_blen - 5'd1);
            end
            S_R: begin
                usr_rready = 1'b1;
                if (usr_rvalid) begin
                    ram_we = 1'b1;
                    ram_a  = r_ramAddr;
                    ram_d  = usr_rdata;
                end
            end
            S_DONE: begin
                dma_done = 1'b1;
            end
            default: begin
                dma_done = 1'b0;
            end
        endcase
    end

    // Register file and transfer datapath. In IDLE a software write is
    // applied after the FSM side effects, so it wins on the same edge.
    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            r_en      <= 1'b0;
            r_done    <= 1'b0;
            r_src     <= '0;
            r_dst     <= '0;
            r_len     <= '0;
            r_araddr  <= '0;
            r_ramAddr <= '0;
            r_remain  <= '0;
            r_blen    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_en) begin
                        if (r_len == 32'd0) begin
                            r_en   <= 1'b0;
                            r_done <= 1'b1;
                        end else begin
                            r_araddr  <= r_src;
                            r_ramAddr <= r_dst;
                            r_remain  <= r_len;
                        end
                    end
                    if (apb_we) begin
                        if (apb_a == APB_AW'(0)) begin
                            r_en <= apb_d[0];
                            if (apb_d[0]) begin
                                r_done <= 1'b0;
                            end
                        end else if (apb_a == APB_AW'(4)) begin
                            r_src <= AXI_AW'({apb_d[31:2], 2'b00});
                        end else if (apb_a == APB_AW'(8)) begin
                            r_dst <= RAM_AW'(apb_d);
                        end else if (apb_a == APB_AW'(12)) begin
                            r_len <= apb_d;
                        end
                    end
                end
                S_AR: begin
                    if (usr_arready) begin
                        r_blen <= w_blen;
                    end
                end
                S_R: begin
                    if (usr_rvalid) begin
                        r_ramAddr <= r_ramAddr + RAM_AW'(1);
                        r_remain  <= w_remainNext;
                        if (usr_rlast) begin
                            r_araddr <= r_araddr + AXI_AW'({r_blen, 2'b00});
                        end
                    end
                end
                S_DONE: begin
                    r_en   <= 1'b0;
                    r_done <= 1'b1;
                end
                default: begin
                    r_en <= 1'b0;
                end
            endcase
        end
    end

    // Combinational register read mux; unmapped addresses read 0.
    always_comb begin
        apb_q = 32'd0;
        if (apb_a == APB_AW'(0)) begin
            apb_q = {29'd0, w_err, r_done, r_en};
        end else if (apb_a == APB_AW'(4)) begin
            apb_q = 32'(r_src);
        end else if (apb_a == APB_AW'(8)) begin
            apb_q = 32'(r_dst);
        end else if (apb_a == APB_AW'(12)) begin
            apb_q = r_len;
        end
    end

endmodule
